serial_frame_rx: RTL

- Receiver end of the single-bit registered serial link: samples a 1-bit stream `idata` every clock and recovers framed words.
- Frame format, fixed, one bit per clock: start bit (1), DATA_W data bits LSB first, optional even-parity bit, stop bit (0). Line idles at 0.
- Recovered words are presented on a valid/ready output with a one-entry holding buffer, plus error and overrun flags.
- Sits downstream of the bit-serial register stage and feeds parallel consumers.

---
 rtl/serial_frame_rx.sv | 95 +++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: recovers start/data/parity/stop framed words from a
// one-bit line and presents them through a one-entry valid/ready buffer.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idata,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  input  logic              oready,
  output logic              perr,
  output logic              ferr,
  output logic              ovrn
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic              par_bad_r;
  logic              load_s;

  // Even parity: a mismatch means the data bits plus the parity bit hold an odd count of ones.
  function automatic logic parity_mismatch(input logic [DATA_W-1:0] word, input logic pbit);
    return (^word) ^ pbit;
  endfunction

  // The buffer can take a new word when it is empty or being drained on this same edge.
  assign load_s = (!ovalid) || oready;

  // Frame FSM, shift register and output holding buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      par_bad_r <= 1'b0;
      odata     <= {DATA_W{1'b0}};
      ovalid    <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      ovrn      <= 1'b0;
    end else begin
      ovrn <= 1'b0;
      if (ovalid && oready) begin
        ovalid <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (idata) begin
            state_r <= DATA;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        DATA: begin
          shift_r[cnt_r] <= idata;
          cnt_r          <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_bad_r <= parity_mismatch(shift_r, idata);
          state_r   <= STOP;
        end
        STOP: begin
          // A high stop bit is flagged, never reinterpreted as a start bit.
          state_r <= IDLE;
          if (load_s) begin
            odata  <= shift_r;
            perr   <= par_bad_r;
            ferr   <= idata;
            ovalid <= 1'b1;
          end else begin
            ovrn <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
